// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit for the Execute stage.
// Iterative ops run IDLE->ABS->CALC(WIDTH)->SIGN->DONE; fast multiply goes IDLE->DONE.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 1,
    parameter int CNT_W    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, ABS, CALC, SIGN, DONE} stateT;

    stateT             stateReg, stateNext;
    logic [1:0]        opReg;
    logic [WIDTH-1:0]  aReg, bReg;
    logic [WIDTH-1:0]  absDReg;
    logic [W2-1:0]     accReg;
    logic              qSignReg, rSignReg;
    logic [CNT_W-1:0]  cntReg;
    logic [WIDTH-1:0]  hiReg, loReg;
    logic              dbzReg;

    logic              accept, fastStart, isSigned, isDiv;
    logic [WIDTH-1:0]  absA, absB;
    logic [W2-1:0]     fastProd;
    logic [W2:0]       divShift;
    logic [WIDTH:0]    divTop;
    logic [WIDTH-1:0]  divDiff;
    logic [W2-1:0]     divNext;
    logic [WIDTH-1:0]  mulAddend;
    logic [WIDTH:0]    mulSum;
    logic [W2-1:0]     mulNext;
    logic [WIDTH-1:0]  resHi, resLo;
    logic [W2-1:0]     prodSigned;
    logic              resDbz;

    assign accept    = start && !cancel;
    assign fastStart = (FAST_MUL != 0) && !op[1];
    assign isSigned  = !opReg[0];
    assign isDiv     = opReg[1];

    // Single-cycle product on the live operands; truncated 2W product is correct for both signednesses.
    if (FAST_MUL != 0) begin : genFast
        logic [W2-1:0] aExt, bExt;
        always_comb begin
            aExt = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
            bExt = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
        end
        assign fastProd = aExt * bExt;
    end else begin : genNoFast
        assign fastProd = '0;
    end

    always_comb begin
        absA = (isSigned && aReg[WIDTH-1]) ? -aReg : aReg;
        absB = (isSigned && bReg[WIDTH-1]) ? -bReg : bReg;
    end

    // Restoring divide step: acc = {remainder, dividend/quotient}.
    always_comb begin
        divShift = {accReg, 1'b0};
        divTop   = divShift[W2:WIDTH];
        divDiff  = divTop[WIDTH-1:0] - absDReg;
        if (divTop >= {1'b0, absDReg})
            divNext = {divDiff, divShift[WIDTH-1:1], 1'b1};
        else
            divNext = divShift[W2-1:0];
    end

    // Shift-add multiply step: acc = {partial product, remaining multiplier bits}.
    always_comb begin
        mulAddend = accReg[0] ? absDReg : {WIDTH{1'b0}};
        mulSum    = {1'b0, accReg[W2-1:WIDTH]} + {1'b0, mulAddend};
        mulNext   = {mulSum, accReg[WIDTH-1:1]};
    end

    always_comb begin
        prodSigned = qSignReg ? -accReg : accReg;
        resDbz     = 1'b0;
        if (isDiv) begin
            resLo = qSignReg ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
            resHi = rSignReg ? -accReg[W2-1:WIDTH] : accReg[W2-1:WIDTH];
            if (bReg == '0) begin
                resLo  = {WIDTH{1'b1}};
                resHi  = aReg;
                resDbz = 1'b1;
            end
        end else begin
            resLo = prodSigned[WIDTH-1:0];
            resHi = prodSigned[W2-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (accept) stateNext = fastStart ? DONE : ABS;
            ABS:  stateNext = cancel ? IDLE : CALC;
            CALC: if (cancel)                            stateNext = IDLE;
                  else if (cntReg == CNT_W'(WIDTH - 1))  stateNext = SIGN;
            SIGN: stateNext = cancel ? IDLE : DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy        = (stateReg != IDLE);
        ready       = (stateReg == DONE);
        hi          = hiReg;
        lo          = loReg;
        div_by_zero = dbzReg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opReg    <= '0;
            aReg     <= '0;
            bReg     <= '0;
            absDReg  <= '0;
            accReg   <= '0;
            qSignReg <= 1'b0;
            rSignReg <= 1'b0;
            cntReg   <= '0;
            hiReg    <= '0;
            loReg    <= '0;
            dbzReg   <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: if (accept) begin
                    opReg <= op;
                    aReg  <= a;
                    bReg  <= b;
                    if (fastStart) begin
                        hiReg  <= fastProd[W2-1:WIDTH];
                        loReg  <= fastProd[WIDTH-1:0];
                        dbzReg <= 1'b0;
                    end
                end
                ABS: begin
                    qSignReg <= isSigned && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
                    rSignReg <= isSigned && aReg[WIDTH-1];
                    cntReg   <= '0;
                    if (isDiv) begin
                        accReg  <= {{WIDTH{1'b0}}, absA};
                        absDReg <= absB;
                    end else begin
                        accReg  <= {{WIDTH{1'b0}}, absB};
                        absDReg <= absA;
                    end
                end
                CALC: begin
                    accReg <= isDiv ? divNext : mulNext;
                    cntReg <= cntReg + CNT_W'(1);
                end
                SIGN: if (!cancel) begin
                    hiReg  <= resHi;
                    loReg  <= resLo;
                    dbzReg <= resDbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a fast-multiply instance and an iterative-multiply instance share stimulus.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        cancel = 1'b0;
    logic [31:0] a = '0, b = '0;

    logic        fBusy, fReady, fDbz, sBusy, sReady, sDbz;
    logic [31:0] fHi, fLo, sHi, sLo;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1)) fastDut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .a(a), .b(b), .busy(fBusy), .ready(fReady), .hi(fHi), .lo(fLo),
        .div_by_zero(fDbz)
    );

    muldiv_unit #(.WIDTH(32), .FAST_MUL(0)) slowDut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .a(a), .b(b), .busy(sBusy), .ready(sReady), .hi(sHi), .lo(sLo),
        .div_by_zero(sDbz)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expDbz;
    } vecT;

    vecT vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launches one op; slow DUT must pulse ready exactly 35 edges after accept.
    task automatic runOp(input vecT v, input bit poke);
        int edges;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        if (!v.op[1]) begin
            check("fast ready", 64'(fReady), 64'd1);
            check("fast busy", 64'(fBusy), 64'd1);
            check("fast hi", 64'(fHi), 64'(v.expHi));
            check("fast lo", 64'(fLo), 64'(v.expLo));
        end
        while (!sReady && edges < 100) begin
            if (poke && (edges == 5 || edges == 20)) begin
                start = 1'b1; op = 2'b01; a = 32'h5; b = 32'h1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (edges == 2 && !v.op[1]) check("fast busy drop", 64'(fBusy), 64'd0);
        end
        start = 1'b0;
        check("latency", 64'(edges), 64'd35);
        check("slow hi", 64'(sHi), 64'(v.expHi));
        check("slow lo", 64'(sLo), 64'(v.expLo));
        check("slow dbz", 64'(sDbz), 64'(v.expDbz));
        if (v.op[1]) begin
            check("fast div ready", 64'(fReady), 64'd1);
            check("fast div hi/lo", {fHi, fLo}, {v.expHi, v.expLo});
            check("fast div dbz", 64'(fDbz), 64'(v.expDbz));
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d edges=%0d", v.op, v.a, v.b, sHi, sLo, sDbz, edges);
        if (poke) begin
            start = 1'b1; op = 2'b11; a = 32'h9; b = 32'h3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("slow idle after done", {62'd0, sBusy, sReady}, 64'd0);
        check("fast idle after done", 64'(fBusy), 64'd0);
    endtask

    initial begin
        bit sawReady;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[4]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{2'b10, 32'h0000_0006, 32'h0000_0003, 32'h0000_0000, 32'h0000_0002, 1'b0};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
        vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[12] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};

        #12;
        check("reset slow outputs", {sBusy, sReady, sDbz, sHi, sLo}, 64'd0);
        check("reset fast outputs", {fBusy, fReady, fDbz, fHi, fLo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) runOp(vecs[i], 1'b0);

        // Cancel mid-divide: no ready, results from the last op retained.
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel busy slow", 64'(sBusy), 64'd0);
        check("cancel busy fast", 64'(fBusy), 64'd0);
        sawReady = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (sReady || fReady) sawReady = 1'b1;
        end
        check("cancel no ready", 64'(sawReady), 64'd0);
        check("cancel keeps hi/lo", {sHi, sLo}, 64'h0000_0000_0000_0001);
        $display("cancelled divu 100/7, hi=%h lo=%h kept", sHi, sLo);

        runOp('{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0}, 1'b0);

        // Start with cancel in the same cycle is not accepted.
        @(negedge clk);
        op = 2'b10; a = 32'd50; b = 32'd5; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("start+cancel slow", 64'(sBusy), 64'd0);
        check("start+cancel fast", 64'(fBusy), 64'd0);
        $display("start with cancel rejected");

        // Starts while busy and during DONE are ignored.
        runOp('{2'b11, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0}, 1'b1);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        op = 2'b11; a = 32'd77; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        check("async reset slow", {sBusy, sReady, sDbz, sHi, sLo}, 64'd0);
        check("async reset fast", {fBusy, fReady, fDbz, fHi, fLo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        sawReady = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (sReady || sBusy) sawReady = 1'b1;
        end
        check("no activity after reset", 64'(sawReady), 64'd0);
        $display("reset mid-CALC returned to idle");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the Execute stage. Successor to the fixed 32-bit divider that drives div_readyE/stall_divE.
- Supports signed and unsigned multiply and divide, with a WIDTH generic.
- Multiply mode is selectable: single-cycle registered or iterative.
- Has an explicit cancel input so that exception flushes abort an in-flight operation. Results feed the HI/LO write path.

Parameters:
- WIDTH, 32: operand width; hi/lo are each WIDTH bits.
- FAST_MUL, 1: 1 = multiply result registered one edge after start; 0 = multiply uses the iterative shift-add path with divide latency.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
- cancel  in  1  abort in-flight op (hazard unit flushE/exception)
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- busy  out  1  high while an op is in flight (start accepted, ready not yet pulsed)
- ready  out  1  one-cycle pulse: hi/lo valid
- hi  out  WIDTH  product high half / remainder
- lo  out  WIDTH  product low half / quotient
- div_by_zero  out  1  valid with ready; 1 if divide with b==0

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, busy=0, ready=0, hi=0, lo=0, div_by_zero=0, counter=0.
- States:
  - IDLE
  - ABS: take magnitudes; record sign of quotient/product = a[MSB]^b[MSB] for signed ops; record sign of remainder = a[MSB].
  - CALC: WIDTH iterations.
  - SIGN: two's-complement correct the results.
  - DONE: ready=1 for one cycle, then IDLE.
- Transitions:
  - IDLE to ABS on start & !cancel.
  - ABS to CALC.
  - CALC to SIGN when counter==WIDTH-1.
  - SIGN to DONE.
  - DONE to IDLE.
  - Fast multiply: IDLE to DONE directly, with the full 2*WIDTH signed/unsigned product registered on the start edge.
- Latency:
  - Start accepted at edge t.
  - Iterative ops: ready high in the cycle after edge t+WIDTH+2, i.e. WIDTH+3 edges total, 35 for WIDTH=32.
  - Fast multiply: ready high in the cycle after edge t, with hi/lo updated at edge t.
- busy: 1 from the start-accept edge until the edge that leaves DONE, inclusive of the DONE cycle.
- Division: restoring radix-2, one quotient bit per CALC cycle, computed on magnitudes.
- Multiply (iterative): shift-add on magnitudes, one bit per CALC cycle; 2*WIDTH accumulator; {hi,lo} = product.
- hi/lo are written only at the SIGN edge (or the fast-multiply start edge). They hold their value until the next completed op; the internal accumulator does not leak to the outputs.
- Divide by zero: the CALC pass still runs with the same latency. Result forced to lo={WIDTH{1}}, hi=a, for both signed and unsigned. div_by_zero=1 for that result.
- Signed overflow: most-negative / -1 gives lo=most-negative, hi=0, with no flag.
- Remainder sign equals dividend sign; quotient truncates toward zero.
- cancel:
  - Cancel in any non-IDLE state: next edge goes to IDLE, busy=0. No ready pulse; hi/lo/div_by_zero unchanged.
  - Cancel during DONE suppresses nothing: ready is already asserted that cycle.
  - start and cancel in the same IDLE cycle: not accepted.
- start while busy is ignored, and operands are not resampled. Start during the DONE cycle is ignored; the next start is accepted in IDLE.
- Reset mid-operation: immediate return to reset values; no ready.

Test Plan:
- WIDTH=32, FAST_MUL=1: multu a=32'hFFFF_FFFF, b=32'h2 → ready one cycle after the accept edge, hi=1, lo=32'hFFFF_FFFE; busy high for exactly one cycle.
- FAST_MUL=0: mult a=-3 (32'hFFFF_FFFD), b=7 → ready after 35 edges, {hi,lo}=64'hFFFF_FFFF_FFFF_FFEB.
- div a=-7, b=2 → lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1), ready at edge 35. divu a=7, b=2 → lo=3, hi=1.
- divu a=32'h1234, b=0 → lo=32'hFFFF_FFFF, hi=32'h1234, div_by_zero=1. Next div 6/3 → div_by_zero=0, lo=2, hi=0.
- Cancel edges:
  - div started, cancel at cycle 10 → busy drops next edge, no ready, hi/lo keep previous values.
  - New start then completes normally.
  - start with cancel in the same cycle → busy stays 0.
- Reset edges:
  - Assert reset low asynchronously mid-CALC → busy/ready/hi/lo go to 0 immediately.
  - start pulses while busy → ignored; the first result is unaffected.
